vfifo_dp_ram_be: RTL and testbench

Single-clock true dual-port synchronous RAM for the versatile FIFO family. It adds four things to the plain dual-port RAM: per-byte write enables, a selectable read-during-write mode, an optional output register stage, and a hardware clear sequencer that sweeps the array to a known value after reset or on request. It is the storage element for wide, multi-byte FIFOs and other FIFO-family blocks that need deterministic contents after reset.

---
 rtl/vfifo_dp_ram_be_if.sv | 45 ++++
 rtl/vfifo_dp_ram_be.sv | 170 +++++++++++++++++
 tb/tb_vfifo_dp_ram_be.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vfifo_dp_ram_be_if.sv
// Bus bundle for the byte-enabled dual-port FIFO RAM: clear handshake plus
// the two independent access ports.
interface vfifo_dp_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  clr;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] adr_a;
    logic [DATA_WIDTH-1:0] d_a;
    logic [BE_WIDTH-1:0]   be_a;
    logic                  we_a;
    logic                  re_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic                  vld_a;

    logic [ADDR_WIDTH-1:0] adr_b;
    logic [DATA_WIDTH-1:0] d_b;
    logic [BE_WIDTH-1:0]   be_b;
    logic                  we_b;
    logic                  re_b;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  vld_b;

    modport master (
        output clr,
        input  busy,
        output adr_a, d_a, be_a, we_a, re_a,
        input  q_a, vld_a,
        output adr_b, d_b, be_b, we_b, re_b,
        input  q_b, vld_b
    );

    modport slave (
        input  clr,
        output busy,
        input  adr_a, d_a, be_a, we_a, re_a,
        output q_a, vld_a,
        input  adr_b, d_b, be_b, we_b, re_b,
        output q_b, vld_b
    );
endinterface

// File: rtl/vfifo_dp_ram_be.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a clear sweep after reset or on request.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | sweep CLR_VALUE into every word; user accesses ignored
//   IDLE  | normal two-port access; clr restarts the sweep
module vfifo_dp_ram_be #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RDW_MODE   = 0,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    vfifo_dp_ram_be_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_WIDTH:0] cnt, cnt_nxt;
    logic                clr_we;
    logic                idle;
    logic                wr_a, wr_b, rd_a, rd_b;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdat_a, rdat_b;

    logic [DATA_WIDTH-1:0] s1_q_a, s1_q_b;
    logic                  s1_vld_a, s1_vld_b;

    function automatic logic [DATA_WIDTH-1:0] merge_be(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] m;
        m = base;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) m[8*i +: 8] = wdata[8*i +: 8];
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The extra counter bit flags the increment past the last address.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + CNT_ONE;
                if (bus.clr) begin
                    cnt_nxt = '0;
                end else if (cnt_nxt[ADDR_WIDTH]) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            IDLE: begin
                if (bus.clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign idle     = (state == IDLE);
    assign bus.busy = (state == CLEAR);

    assign wr_a = idle & bus.we_a;
    assign wr_b = idle & bus.we_b;
    assign rd_a = idle & bus.re_a;
    assign rd_b = idle & bus.re_b;

    // Port A is applied last so it owns any byte both ports enable.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt[ADDR_WIDTH-1:0]] <= CLR_VALUE;
        end else begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_b && bus.be_b[i]) mem[bus.adr_b][8*i +: 8] <= bus.d_b[8*i +: 8];
            end
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_a && bus.be_a[i]) mem[bus.adr_a][8*i +: 8] <= bus.d_a[8*i +: 8];
            end
        end
    end

    // Write-first bypass mirrors the array update order, so reads see the same merge.
    always_comb begin
        rdat_a = mem[bus.adr_a];
        rdat_b = mem[bus.adr_b];
        if (RDW_MODE != 0) begin
            if (wr_b && (bus.adr_b == bus.adr_a)) rdat_a = merge_be(rdat_a, bus.d_b, bus.be_b);
            if (wr_a)                             rdat_a = merge_be(rdat_a, bus.d_a, bus.be_a);
            if (wr_b)                             rdat_b = merge_be(rdat_b, bus.d_b, bus.be_b);
            if (wr_a && (bus.adr_a == bus.adr_b)) rdat_b = merge_be(rdat_b, bus.d_a, bus.be_a);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q_a   <= '0;
            s1_q_b   <= '0;
            s1_vld_a <= 1'b0;
            s1_vld_b <= 1'b0;
        end else begin
            s1_vld_a <= rd_a;
            s1_vld_b <= rd_b;
            if (rd_a) s1_q_a <= rdat_a;
            if (rd_b) s1_q_b <= rdat_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s2_q_a, s2_q_b;
            logic                  s2_vld_a, s2_vld_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_q_a   <= '0;
                    s2_q_b   <= '0;
                    s2_vld_a <= 1'b0;
                    s2_vld_b <= 1'b0;
                end else begin
                    s2_vld_a <= s1_vld_a;
                    s2_vld_b <= s1_vld_b;
                    if (s1_vld_a) s2_q_a <= s1_q_a;
                    if (s1_vld_b) s2_q_b <= s1_q_b;
                end
            end

            assign bus.q_a   = s2_q_a;
            assign bus.q_b   = s2_q_b;
            assign bus.vld_a = s2_vld_a;
            assign bus.vld_b = s2_vld_b;
        end else begin : g_no_out_reg
            assign bus.q_a   = s1_q_a;
            assign bus.q_b   = s1_q_b;
            assign bus.vld_a = s1_vld_a;
            assign bus.vld_b = s1_vld_b;
        end
    endgenerate
endmodule

// File: tb/tb_vfifo_dp_ram_be.sv
// Bench for vfifo_dp_ram_be: two instances (read-first/no out reg, write-first/out reg)
// driven with identical stimulus; reads are scored against a queue of expected words.
module tb_vfifo_dp_ram_be;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = DW / 8;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic          clr = 1'b0;
    logic [AW-1:0] adr_a = '0, adr_b = '0;
    logic [DW-1:0] d_a = '0, d_b = '0;
    logic [BW-1:0] be_a = '0, be_b = '0;
    logic          we_a = 1'b0, we_b = 1'b0, re_a = 1'b0, re_b = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // index: 0 = u0 port A, 1 = u0 port B, 2 = u1 port A, 3 = u1 port B
    exp_t          sbq [4][$];
    logic [3:0]    vld_v;
    logic [DW-1:0] q_v [4];

    logic [DW-1:0] e0 [16];
    logic [DW-1:0] e1 [16];

    vfifo_dp_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    vfifo_dp_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.clr = clr;   assign bus1.clr = clr;
    assign bus0.adr_a = adr_a; assign bus1.adr_a = adr_a;
    assign bus0.d_a = d_a;   assign bus1.d_a = d_a;
    assign bus0.be_a = be_a; assign bus1.be_a = be_a;
    assign bus0.we_a = we_a; assign bus1.we_a = we_a;
    assign bus0.re_a = re_a; assign bus1.re_a = re_a;
    assign bus0.adr_b = adr_b; assign bus1.adr_b = adr_b;
    assign bus0.d_b = d_b;   assign bus1.d_b = d_b;
    assign bus0.be_b = be_b; assign bus1.be_b = be_b;
    assign bus0.we_b = we_b; assign bus1.we_b = we_b;
    assign bus0.re_b = re_b; assign bus1.re_b = re_b;

    assign vld_v = {bus1.vld_b, bus1.vld_a, bus0.vld_b, bus0.vld_a};
    assign q_v[0] = bus0.q_a;
    assign q_v[1] = bus0.q_b;
    assign q_v[2] = bus1.q_a;
    assign q_v[3] = bus1.q_b;

    vfifo_dp_ram_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0),
        .CLR_VALUE(32'hDEADBEEF)
    ) u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    vfifo_dp_ram_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1),
        .CLR_VALUE(32'h0)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every vld must match the oldest expectation in data and arrival cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (vld_v[k]) begin
                n_checks++;
                if (sbq[k].size() == 0) begin
                    $display("FAIL read_unexpected sb%0d: got vld with q=%h at cycle %0d, required no read", k, q_v[k], cyc);
                end else begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    if (q_v[k] !== e.data || cyc != e.due)
                        $display("FAIL read_data sb%0d: got %h at cycle %0d, required %h at cycle %0d", k, q_v[k], cyc, e.data, e.due);
                    else
                        n_pass++;
                end
            end else if (sbq[k].size() > 0 && sbq[k][0].due < cyc) begin
                exp_t e;
                e = sbq[k].pop_front();
                n_checks++;
                $display("FAIL read_missing sb%0d: got no vld by cycle %0d, required %h at cycle %0d", k, cyc, e.data, e.due);
            end
        end
    end

    task automatic expect_read(input int port, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        exp_t e;
        e.due = cyc + 1; e.data = d0; sbq[port].push_back(e);
        e.due = cyc + 2; e.data = d1; sbq[2 + port].push_back(e);
    endtask

    task automatic quiet();
        clr = 1'b0;
        we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0;
        be_a = '0; be_b = '0;
    endtask

    task automatic test_reset();
        int n0, n1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus0.busy, bus0.vld_a, bus0.vld_b, bus0.q_a, bus0.q_b} !== {3'b100, 64'h0})
            $display("FAIL reset_state_u0: got busy/vld_a/vld_b=%b%b%b q_a=%h q_b=%h, required 100 0 0",
                     bus0.busy, bus0.vld_a, bus0.vld_b, bus0.q_a, bus0.q_b);
        else n_pass++;
        n_checks++;
        if ({bus1.busy, bus1.vld_a, bus1.vld_b, bus1.q_a, bus1.q_b} !== {3'b100, 64'h0})
            $display("FAIL reset_state_u1: got busy/vld_a/vld_b=%b%b%b q_a=%h q_b=%h, required 100 0 0",
                     bus1.busy, bus1.vld_a, bus1.vld_b, bus1.q_a, bus1.q_b);
        else n_pass++;

        rst = 1'b0;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus0.busy) n0++;
            if (bus1.busy) n1++;
            if (!bus0.busy && !bus1.busy) break;
            @(negedge clk);
        end
        n_checks++;
        if (n0 != 16) $display("FAIL reset_busy_u0: got %0d busy cycles, required 16", n0);
        else n_pass++;
        n_checks++;
        if (n1 != 16) $display("FAIL reset_busy_u1: got %0d busy cycles, required 16", n1);
        else n_pass++;

        for (int i = 0; i < 16; i++) begin
            e0[i] = 32'hDEADBEEF;
            e1[i] = 32'h0;
        end
        for (int i = 0; i < 16; i++) begin
            adr_b = AW'(i); re_b = 1'b1;
            expect_read(1, e0[i], e1[i]);
            @(negedge clk);
        end
        quiet();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_byte_enables();
        we_a = 1'b1; adr_a = 4'd3; d_a = 32'h11223344; be_a = 4'b1111;
        @(negedge clk);
        d_a = 32'hAABBCCDD; be_a = 4'b0101;
        @(negedge clk);
        d_a = 32'hFFFFFFFF; be_a = 4'b0000;
        @(negedge clk);
        we_a = 1'b0; re_a = 1'b1; re_b = 1'b1; adr_b = 4'd3;
        e0[3] = 32'h11BB33DD; e1[3] = 32'h11BB33DD;
        expect_read(0, e0[3], e1[3]);
        expect_read(1, e0[3], e1[3]);
        @(negedge clk);
        quiet();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rdw();
        we_a = 1'b1; adr_a = 4'd5; d_a = 32'h0; be_a = 4'hF;
        @(negedge clk);
        d_a = 32'hFFFF0000; re_b = 1'b1; adr_b = 4'd5;
        expect_read(1, 32'h0, 32'hFFFF0000);
        @(negedge clk);
        d_a = 32'h00001234; be_a = 4'b0011; re_a = 1'b1;
        expect_read(0, 32'hFFFF0000, 32'hFFFF1234);
        expect_read(1, 32'hFFFF0000, 32'hFFFF1234);
        e0[5] = 32'hFFFF1234; e1[5] = 32'hFFFF1234;
        @(negedge clk);
        re_b = 1'b0;
        adr_a = 4'd6; d_a = 32'h000000AA; be_a = 4'b0001;
        we_b = 1'b1; adr_b = 4'd6; d_b = 32'hBB000000; be_b = 4'b1000;
        expect_read(0, e0[6], 32'hBB0000AA);
        e0[6] = 32'hBBADBEAA; e1[6] = 32'hBB0000AA;
        @(negedge clk);
        quiet();
        re_b = 1'b1; adr_b = 4'd6;
        expect_read(1, e0[6], e1[6]);
        @(negedge clk);
        quiet();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_collision();
        we_a = 1'b1; adr_a = 4'd7; d_a = 32'h01010101; be_a = 4'b0011;
        we_b = 1'b1; adr_b = 4'd7; d_b = 32'h02020202; be_b = 4'b0110;
        @(negedge clk);
        quiet();
        e0[7] = 32'hDE020101; e1[7] = 32'h00020101;
        re_a = 1'b1; adr_a = 4'd7;
        expect_read(0, e0[7], e1[7]);
        @(negedge clk);
        quiet();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_streaming();
        int nv0, nv1;
        nv0 = 0; nv1 = 0;
        for (int i = 0; i < 8; i++) begin
            re_a = 1'b1; adr_a = AW'(i);
            expect_read(0, e0[i], e1[i]);
            @(negedge clk);
            if (bus0.vld_a) nv0++;
            if (bus1.vld_a) nv1++;
        end
        quiet();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus0.vld_a) nv0++;
            if (bus1.vld_a) nv1++;
        end
        n_checks++;
        if (nv0 != 8) $display("FAIL stream_vld_u0: got %0d vld cycles, required 8", nv0);
        else n_pass++;
        n_checks++;
        if (nv1 != 8) $display("FAIL stream_vld_u1: got %0d vld cycles, required 8", nv1);
        else n_pass++;
    endtask

    task automatic test_clear_interrupt();
        int n, n0, n1;
        clr = 1'b1; re_b = 1'b1; adr_b = 4'd3;
        expect_read(1, e0[3], e1[3]);
        @(negedge clk);
        quiet();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus0.busy && bus1.busy) n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 10) $display("FAIL clr_busy_rise: got %0d busy cycles before rst, required 10", n);
        else n_pass++;

        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus0.busy, bus0.vld_b, bus0.q_b, bus1.busy, bus1.vld_b, bus1.q_b} !== {2'b10, 32'h0, 2'b10, 32'h0})
            $display("FAIL rst_in_flight: got u0 busy/vld=%b%b q_b=%h u1 busy/vld=%b%b q_b=%h, required 10 0",
                     bus0.busy, bus0.vld_b, bus0.q_b, bus1.busy, bus1.vld_b, bus1.q_b);
        else n_pass++;
        repeat (2) @(negedge clk);

        rst = 1'b0;
        we_a = 1'b1; adr_a = 4'd0; d_a = 32'h12345678; be_a = 4'hF;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus0.busy) n0++;
            if (bus1.busy) n1++;
            if (!bus0.busy && !bus1.busy) break;
            @(negedge clk);
        end
        quiet();
        n_checks++;
        if (n0 != 16) $display("FAIL restart_busy_u0: got %0d busy cycles, required 16", n0);
        else n_pass++;
        n_checks++;
        if (n1 != 16) $display("FAIL restart_busy_u1: got %0d busy cycles, required 16", n1);
        else n_pass++;

        for (int i = 0; i < 16; i++) begin
            e0[i] = 32'hDEADBEEF;
            e1[i] = 32'h0;
        end
        re_a = 1'b1; adr_a = 4'd0;
        expect_read(0, e0[0], e1[0]);
        for (int i = 0; i < 16; i++) begin
            re_b = 1'b1; adr_b = AW'(i);
            expect_read(1, e0[i], e1[i]);
            @(negedge clk);
            re_a = 1'b0;
        end
        quiet();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        quiet();
        test_reset();
        test_byte_enables();
        test_rdw();
        test_collision();
        test_streaming();
        test_clear_interrupt();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (sbq[k].size() != 0)
                $display("FAIL sb_drain sb%0d: got %0d outstanding reads, required 0", k, sbq[k].size());
            else n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
